// File: rtl/misr_pkg.sv
// Shared types and default constants for the MISR/LFSR signature analyser.
package misr_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } misr_state_e;

  // CRC-16-style tap mask for x^16+x^12+x^3+x^1+1.
  localparam logic [15:0] DefaultPoly = 16'h100B;
  localparam logic [63:0] DefaultSeed = '1;

endpackage

// File: rtl/misr_core.sv
// Signature register: loads the seed, or shifts with polynomial feedback and optional data fold-in.
module misr_core
  import misr_pkg::*;
#(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(DefaultPoly),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(DefaultSeed)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic             data_gate,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] sig
);

  logic [WIDTH-1:0] sig_q, sig_d;
  logic [WIDTH-1:0] feedback;
  logic [WIDTH-1:0] gated_data;

  always_comb begin
    feedback   = sig_q[WIDTH-1] ? POLY : '0;
    gated_data = data_gate ? data : '0;
    sig_d      = sig_q;
    if (load) begin
      sig_d = SEED;
    end else if (en) begin
      sig_d = {sig_q[WIDTH-2:0], 1'b0} ^ feedback ^ gated_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sig_q <= SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/misr_analyzer.sv
// Run controller for a MISR compactor / LFSR generator with bounded update count.
// Optional golden-signature comparator enabled by defining MISR_COMPARE_EN.
module misr_analyzer
  import misr_pkg::*;
#(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(DefaultPoly),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(DefaultSeed),
  parameter int unsigned      CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in,
`ifdef MISR_COMPARE_EN
  input  logic [WIDTH-1:0] golden,
  output logic             pass,
  output logic             fail,
`endif
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);

  misr_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             mode_q, mode_d;
  logic             load;
  logic             update;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    mode_d  = mode_q;
    load    = 1'b0;
    update  = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          load    = 1'b1;
          len_d   = len;
          mode_d  = mode;
          cnt_d   = '0;
          state_d = (len == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        update = mode_q | in_valid;
        if (update) begin
          cnt_d = cnt_q + CNT_W'(1);
          // len_q is non-zero in RUN, so the counter stops at len and never wraps.
          if (cnt_q == len_q - CNT_W'(1)) begin
            state_d = StDone;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      len_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
    end
  end

  misr_core #(
    .WIDTH(WIDTH),
    .POLY (POLY),
    .SEED (SEED)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .en       (update),
    .data_gate(~mode_q),
    .data     (in),
    .sig      (out)
  );

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);

`ifdef MISR_COMPARE_EN
  logic match;
  assign match = (out == golden);
  assign pass  = done & match;
  assign fail  = done & ~match;
`endif

endmodule

// File: tb/tb_misr_analyzer.sv
// Randomised and directed self-checking bench for misr_analyzer against a behavioural model.
module tb_misr_analyzer;

  localparam int unsigned     WIDTH = 16;
  localparam int unsigned     CNT_W = 16;
  localparam logic [15:0]     POLY  = 16'h100B;
  localparam logic [15:0]     SEED  = 16'hFFFF;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             mode = 1'b0;
  logic [CNT_W-1:0] len = '0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] tb_in = '0;
  logic [WIDTH-1:0] golden = '0;
  logic [WIDTH-1:0] tb_out;
  logic             busy, done;
  logic             pass, fail;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state.
  logic [15:0] m_sig = SEED;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic        m_mode = 1'b0;
  int          m_left = 0;

  always #5 clk = ~clk;

  misr_analyzer #(
    .WIDTH(WIDTH),
    .POLY (POLY),
    .SEED (SEED),
    .CNT_W(CNT_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .mode    (mode),
    .len     (len),
    .in_valid(in_valid),
    .in      (tb_in),
`ifdef MISR_COMPARE_EN
    .golden  (golden),
    .pass    (pass),
    .fail    (fail),
`endif
    .out     (tb_out),
    .busy    (busy),
    .done    (done)
  );

`ifndef MISR_COMPARE_EN
  assign pass = 1'b0;
  assign fail = 1'b0;
`endif

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Galois step as arithmetic: multiply by x modulo the polynomial, then add data.
  function automatic logic [15:0] next_sig(input logic [15:0] s, input logic [15:0] d);
    int unsigned v;
    v = int'(s) * 2;
    if (v >= 32'h10000) v = (v - 32'h10000) ^ int'(POLY);
    return 16'(v) ^ d;
  endfunction

  task automatic model_update();
    if (reset) begin
      m_sig  = SEED;
      m_busy = 1'b0;
      m_done = 1'b0;
    end else if (!m_busy) begin
      if (start) begin
        m_sig  = SEED;
        m_mode = mode;
        m_left = int'(len);
        m_busy = (len != 0);
        m_done = (len == 0);
      end
    end else if (m_mode || in_valid) begin
      m_sig = next_sig(m_sig, m_mode ? 16'h0 : tb_in);
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_eq("out", tb_out, m_sig);
    check_eq("busy", busy, m_busy);
    check_eq("done", done, m_done);
`ifdef MISR_COMPARE_EN
    check_eq("pass", pass, m_done && (m_sig == golden));
    check_eq("fail", fail, m_done && (m_sig != golden));
`endif
  endtask

  initial begin
    // Reset state.
    tick();
    tick();
    reset = 1'b0;
    check_eq("rst_out", tb_out, 16'hFFFF);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);

    // len=0: straight to DONE with the seed.
    golden = 16'hFFFF;
    start = 1'b1; len = 0;
    tick();
    start = 1'b0;
    check_eq("len0_done", done, 1'b1);
    check_eq("len0_out", tb_out, 16'hFFFF);
`ifdef MISR_COMPARE_EN
    check_eq("len0_pass", pass, 1'b1);
`endif

    // MISR, len=1, one zero beat.
    start = 1'b1; len = 1; mode = 1'b0;
    tick();
    start = 1'b0;
    check_eq("len1_busy", busy, 1'b1);
    in_valid = 1'b1; tb_in = 16'h0000;
    tick();
    in_valid = 1'b0;
    check_eq("len1_out", tb_out, 16'hEFF5);
    check_eq("len1_done", done, 1'b1);

    // MISR, len=2, valid pattern 1,0,1.
    start = 1'b1; len = 2;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    tick();
    check_eq("gap_out1", tb_out, 16'hEFF5);
    in_valid = 1'b0;
    tick();
    check_eq("gap_hold", tb_out, 16'hEFF5);
    check_eq("gap_busy", busy, 1'b1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_eq("gap_out2", tb_out, 16'hCFE1);
    check_eq("gap_done", done, 1'b1);

    // LFSR, len=3, input ignored; start in RUN ignored.
    start = 1'b1; len = 3; mode = 1'b1;
    tick();
    mode = 1'b0;
    tb_in = 16'($urandom); in_valid = 1'b0;
    tick();
    check_eq("lfsr1", tb_out, 16'hEFF5);
    tb_in = 16'($urandom); in_valid = 1'b1;
    tick();
    check_eq("lfsr2", tb_out, 16'hCFE1);
    start = 1'b0;
    tb_in = 16'($urandom);
    tick();
    in_valid = 1'b0;
    check_eq("lfsr3", tb_out, 16'h8FC9);
    check_eq("lfsr_done", done, 1'b1);

    // Golden mismatch held in DONE, cleared by a new start.
    golden = 16'hCFE0; tb_in = '0;
    start = 1'b1; len = 2; mode = 1'b0;
    tick();
    start = 1'b0; in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    check_eq("mis_out", tb_out, 16'hCFE1);
    tick();
    check_eq("mis_held", tb_out, 16'hCFE1);
`ifdef MISR_COMPARE_EN
    check_eq("mis_fail", fail, 1'b1);
    check_eq("mis_pass", pass, 1'b0);
`endif
    start = 1'b1; len = 3;
    tick();
    start = 1'b0;
    check_eq("restart_busy", busy, 1'b1);
`ifdef MISR_COMPARE_EN
    check_eq("restart_fail", fail, 1'b0);
`endif
    in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;

    // Reset mid-run, then a normal run.
    start = 1'b1; len = 5; mode = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("midrst_out", tb_out, 16'hFFFF);
    check_eq("midrst_busy", busy, 1'b0);
    check_eq("midrst_done", done, 1'b0);
    start = 1'b1; len = 2; mode = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check_eq("after_rst_out", tb_out, 16'hCFE1);
    check_eq("after_rst_done", done, 1'b1);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      start    = ($urandom_range(0, 5) == 0);
      len      = CNT_W'($urandom_range(0, 12));
      mode     = $urandom_range(0, 1) != 0;
      in_valid = $urandom_range(0, 1) != 0;
      tb_in    = 16'($urandom);
      reset    = ($urandom_range(0, 80) == 0);
      golden   = ($urandom_range(0, 1) != 0) ? m_sig : 16'($urandom);
      tick();
    end
    reset = 1'b0; start = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/misr_analyzer.md
MISR_ANALYZER -- requirements
Module: misr_analyzer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning signature and input width (4..64).
REQ-002 The block SHALL have parameter POLY, default 16'h100B, meaning the feedback tap mask for x^16+x^12+x^3+x^1+1 (bit i set = tap into stage i).
REQ-003 The block SHALL have parameter SEED, default all-ones, meaning the signature value after reset or start.
REQ-004 The block SHALL have parameter CNT_W, default 16, meaning compaction length counter width.
REQ-005 The block SHALL have port clk, input, 1, meaning the single clock, rising edge.
REQ-006 The block SHALL have port reset, input, 1, meaning reset, synchronous and active-high.
REQ-007 The block SHALL have port start, input, 1, meaning begin compaction (pulse).
REQ-008 The block SHALL have port mode, input, 1, meaning 0 = MISR compaction and 1 = free-running LFSR pattern generation; sampled at start.
REQ-009 The block SHALL have port len, input, CNT_W, meaning number of updates; sampled at start.
REQ-010 The block SHALL have port in_valid, input, 1, meaning in is valid this cycle.
REQ-011 The block SHALL have port in, input, WIDTH, meaning data to compact.
REQ-012 The block SHALL have port golden, input, WIDTH, meaning expected signature (macro-gated).
REQ-013 The block SHALL have port out, output, WIDTH, meaning current signature.
REQ-014 The block SHALL have ports busy and done, output, 1 each, meaning run in progress and run complete.
REQ-015 The block SHALL have ports pass and fail, output, 1 each, meaning compare result (macro-gated).

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-017 When start=1 in IDLE or DONE, the block SHALL load out=SEED, latch len and mode, clear the count and enter RUN (len!=0) or DONE (len==0) on the next edge.
REQ-018 An update SHALL be next = {out[WIDTH-2:0],1'b0} ^ (out[WIDTH-1] ? POLY : 0) ^ d, where d = in in MISR mode and 0 in LFSR mode.
REQ-019 In RUN, an update SHALL occur on every cycle with in_valid=1 in MISR mode, and on every cycle in LFSR mode.
REQ-020 In RUN, out SHALL hold its value on in_valid=0 cycles in MISR mode.
REQ-021 The update that brings the count to len SHALL move the FSM to DONE at the same edge, so done=1 in the next cycle.
REQ-022 busy SHALL equal (state==RUN) and done SHALL equal (state==DONE).
REQ-023 In DONE, out SHALL hold until start or reset.
REQ-024 start during RUN SHALL be ignored.
REQ-025 The counter SHALL be CNT_W bits and SHALL never wrap, because the terminal check stops it at len.
REQ-026 The len maximum SHALL be 2^CNT_W-1.

Reset
REQ-027 On reset=1 at a clock edge, the block SHALL set state=IDLE, out=SEED, count=0, busy=0, done=0, pass=0 and fail=0.
REQ-028 Reset SHALL take priority over start and in_valid, including when asserted mid-RUN.

Configuration
REQ-029 With MISR_COMPARE_EN defined, ports golden, pass and fail SHALL exist, with pass=(out==golden) and fail=!pass while in DONE, and both 0 otherwise.
REQ-030 Without MISR_COMPARE_EN, golden, pass, fail and the comparator SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-031 Package misr_pkg SHALL hold the state enum (IDLE/RUN/DONE), the default POLY constant 16'h100B and the default SEED constant.
REQ-032 Sub-module misr_core SHALL hold the signature register and update function (load, enable, data-gate inputs).
REQ-033 The FSM and counter SHALL reside in misr_analyzer.

Verification (WIDTH=16, defaults)
REQ-034 Reset, start with len=0 and golden=16'hFFFF -> done=1 next cycle, out=16'hFFFF, pass=1.
REQ-035 MISR mode, len=1, in=16'h0000 valid -> out=16'hEFF5, done=1 one cycle after the valid beat.
REQ-036 MISR mode, len=2, in=0 with in_valid pattern 1,0,1 -> out=16'hEFF5 then held, then 16'hCFE1, with done=1 after the third cycle.
REQ-037 LFSR mode, len=3, random in -> out sequence 16'hEFF5, 16'hCFE1, 16'h8FC9, with in ignored.
REQ-038 len=2 run finishing at 16'hCFE1 with golden=16'hCFE0 -> fail=1, pass=0, both held in DONE; start then clears them.
REQ-039 Reset asserted in cycle 2 of a len=5 run -> next cycle out=16'hFFFF, busy=0, done=0; a later start runs normally.
